// File: rtl/led_pio_sequencer.sv
// Avalon-MM bridge and LED pattern engine in front of the 14-bit LED PIO s1 port.
// Optional `LED_SEQ_IRQ_EN adds the irq output and the STATUS bit2 wrap flag.
module led_pio_sequencer #(
  parameter int LED_W    = 14,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          cpu_address,
  input  logic                cpu_chipselect,
  input  logic                cpu_write_n,
  input  logic [31:0]         cpu_writedata,
  output logic [31:0]         cpu_readdata,
  output logic [1:0]          pio_address,
  output logic                pio_chipselect,
  output logic                pio_write_n,
  output logic [31:0]         pio_writedata,
  input  logic [31:0]         pio_readdata
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic                irq
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t               state_q, state_d;
  logic                 ctrl_en;
  logic [1:0]           ctrl_mode;
  logic [LED_W-1:0]     ctrl_seed;
  logic [PERIOD_W-1:0]  period_q;
  logic [PERIOD_W-1:0]  cnt_q;
  logic [LED_W-1:0]     pattern_q, pat_next;
  logic                 dir_q, dir_next;   // 0 = left (toward MSB), 1 = right
  logic                 pending_q;

  logic cpu_wr, cpu_pio, ctrl_wr, en_rise, en_clear, eng_grant, tick, tick_upd;

  assign cpu_wr    = cpu_chipselect && !cpu_write_n;
  assign cpu_pio   = cpu_chipselect && (cpu_address == 2'd0);
  assign ctrl_wr   = cpu_wr && (cpu_address == 2'd1);
  assign en_rise   = ctrl_wr && cpu_writedata[0] && !ctrl_en;
  assign en_clear  = ctrl_wr && !cpu_writedata[0];
  // A disabling CTRL write also suppresses an engine write in the same cycle.
  assign eng_grant = (state_q == ISSUE) && !cpu_pio && !en_clear;
  assign tick      = (state_q == WAIT) && (cnt_q == '0) && !en_clear;
  assign tick_upd  = tick && (ctrl_mode != 2'd3);

`ifdef LED_SEQ_IRQ_EN
  logic pat_evt;
  logic wrap_flag_q;
  assign irq = wrap_flag_q;
`endif

  always_comb begin
    pat_next = pattern_q;
    dir_next = dir_q;
`ifdef LED_SEQ_IRQ_EN
    pat_evt  = 1'b0;
`endif
    case (ctrl_mode)
      2'd0: begin
        pat_next = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
`ifdef LED_SEQ_IRQ_EN
        pat_evt  = pattern_q[LED_W-1];
`endif
      end
      2'd1: begin
        if (!dir_q) begin
          pat_next = pattern_q << 1;
          if (pat_next[LED_W-1]) dir_next = 1'b1;
        end else begin
          pat_next = pattern_q >> 1;
          if (pat_next[0]) dir_next = 1'b0;
        end
`ifdef LED_SEQ_IRQ_EN
        pat_evt  = (dir_next != dir_q);
`endif
      end
      2'd2: begin
        pat_next = pattern_q + LED_W'(1);
`ifdef LED_SEQ_IRQ_EN
        pat_evt  = &pattern_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    pio_address    = '0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    cpu_readdata   = '0;

    case (state_q)
      IDLE:    if (en_rise)   state_d = ISSUE;
      ISSUE:   if (eng_grant) state_d = WAIT;
      WAIT:    if (tick_upd)  state_d = ISSUE;
      default:                state_d = IDLE;
    endcase
    if (en_clear) state_d = IDLE;

    if (cpu_pio) begin
      pio_chipselect = 1'b1;
      pio_write_n    = cpu_write_n;
      pio_writedata  = cpu_writedata;
    end else if (eng_grant) begin
      pio_chipselect = 1'b1;
      pio_write_n    = 1'b0;
      pio_writedata[LED_W-1:0] = pattern_q;
    end

    if (cpu_chipselect && cpu_write_n) begin
      case (cpu_address)
        2'd0: cpu_readdata = pio_readdata;
        2'd1: begin
          cpu_readdata[0]            = ctrl_en;
          cpu_readdata[2:1]          = ctrl_mode;
          cpu_readdata[16 +: LED_W]  = ctrl_seed;
        end
        2'd2: cpu_readdata[PERIOD_W-1:0] = period_q;
        default: begin
          cpu_readdata[0]            = (state_q != IDLE);
          cpu_readdata[1]            = pending_q;
`ifdef LED_SEQ_IRQ_EN
          cpu_readdata[2]            = wrap_flag_q;
`endif
          cpu_readdata[16 +: LED_W]  = pattern_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= '0;
      ctrl_seed <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      pattern_q <= '0;
      dir_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_mode <= cpu_writedata[2:1];
        // Re-enabling while enabled only changes mode; the seed is kept.
        if (!(ctrl_en && cpu_writedata[0])) begin
          ctrl_en   <= cpu_writedata[0];
          ctrl_seed <= cpu_writedata[16 +: LED_W];
        end
      end
      if (cpu_wr && (cpu_address == 2'd2)) period_q <= cpu_writedata[PERIOD_W-1:0];

      if (en_rise) begin
        pattern_q <= cpu_writedata[16 +: LED_W];
        dir_q     <= 1'b0;
      end else if (tick_upd) begin
        pattern_q <= pat_next;
        dir_q     <= dir_next;
      end

      if (en_clear)               pending_q <= 1'b0;
      else if (state_q == ISSUE)  pending_q <= !eng_grant;

      if (eng_grant)              cnt_q <= period_q;
      else if (state_q == WAIT)   cnt_q <= (cnt_q == '0) ? period_q : cnt_q - PERIOD_W'(1);
    end
  end

`ifdef LED_SEQ_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                          wrap_flag_q <= 1'b0;
    else if (tick_upd && pat_evt)                          wrap_flag_q <= 1'b1;
    else if (cpu_wr && (cpu_address == 2'd3) && cpu_writedata[2]) wrap_flag_q <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Self-checking bench for led_pio_sequencer: directed scenarios plus randomized pattern runs
// compared against an arithmetic model of the pattern rules and write timing.
module tb_led_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  cpu_address = '0;
  logic        cpu_chipselect = 1'b0;
  logic        cpu_write_n = 1'b1;
  logic [31:0] cpu_writedata = '0;
  logic [31:0] cpu_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata = 32'h0000_1234;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  led_pio_sequencer #(.LED_W(14), .PERIOD_W(24)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_address    (cpu_address),
    .cpu_chipselect (cpu_chipselect),
    .cpu_write_n    (cpu_write_n),
    .cpu_writedata  (cpu_writedata),
    .cpu_readdata   (cpu_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] data; } wr_t;
  wr_t q[$];
  int cyc = 0;
  int last_cyc = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) q.push_back('{cyc, pio_writedata});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cpu_chipselect = 1'b1; cpu_write_n = 1'b0; cpu_address = a; cpu_writedata = d;
    @(negedge clk); last_cyc = cyc;
    @(posedge clk); #1;
    cpu_chipselect = 1'b0; cpu_write_n = 1'b1; cpu_address = '0; cpu_writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    cpu_chipselect = 1'b1; cpu_write_n = 1'b1; cpu_address = a;
    @(negedge clk); d = cpu_readdata;
    @(posedge clk); #1;
    cpu_chipselect = 1'b0; cpu_address = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int b = budget;
    while (q.size() < n && b > 0) begin @(posedge clk); #1; b--; end
    chk({tag, "_write_count"}, 32'(q.size()), 32'(n));
  endtask

  function automatic logic [31:0] qd(input int k);
    return (k < q.size()) ? q[k].data : 32'hDEAD_BEEF;
  endfunction

  // Reference rules: 0 rotate, 1 bounce, 2 count on a 14-bit value; d=0 left, 1 right.
  task automatic model_step(input int mode, inout int v, inout int d, output bit evt);
    int n;
    evt = 0;
    if (mode == 0) begin
      n = (v * 2) % 16384 + v / 8192;
      evt = (v >= 8192);
    end else if (mode == 1) begin
      if (d == 0) begin
        n = (v * 2) % 16384;
        if (n >= 8192) begin d = 1; evt = 1; end
      end else begin
        n = v / 2;
        if (n % 2 == 1) begin d = 0; evt = 1; end
      end
    end else begin
      n = (v + 1) % 16384;
      evt = (n == 0);
    end
    v = n;
  endtask

  task automatic run_seq(input string tag, input int mode, input int seed, input int period, input int n);
    int v, d, t0, nq;
    bit evt, flag;
    logic [31:0] st;
    bus_write(2'd2, 32'(period));
    q.delete();
    bus_write(2'd1, 32'(1 + mode * 2 + seed * 65536));
    t0 = last_cyc;
    wait_writes(tag, n, (period + 3) * n + 20);
    bus_write(2'd1, 32'd0);
    bus_read(2'd3, st);
    chk({tag, "_busy_pend_after_clear"}, 32'(st[1:0]), 32'd0);
    v = seed; d = 0; flag = 0;
    for (int k = 0; k < n && k < q.size(); k++) begin
      if (k > 0) begin model_step(mode, v, d, evt); flag |= evt; end
      chk($sformatf("%s_val%0d", tag, k), q[k].data, 32'(v));
      chk($sformatf("%s_cyc%0d", tag, k), 32'(q[k].cyc), 32'(t0 + 1 + k * (period + 2)));
    end
`ifdef LED_SEQ_IRQ_EN
    if (period > 0 || flag) begin
      chk({tag, "_flag"}, 32'(st[2]), 32'(flag));
      chk({tag, "_irq"}, 32'(irq), 32'(flag));
    end
    bus_write(2'd3, 32'd4);
    bus_read(2'd3, st);
    chk({tag, "_flag_cleared"}, 32'(st[2]), 32'd0);
`endif
    nq = q.size();
    idle(30);
    chk({tag, "_no_writes_after_clear"}, 32'(q.size()), 32'(nq));
  endtask

  initial begin
    logic [31:0] r;
    int t0;

    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_pio_cs", 32'(pio_chipselect), 32'd0);
    chk("rst_pio_wn", 32'(pio_write_n), 32'd1);
    chk("rst_pio_wd", pio_writedata, 32'd0);
    chk("rst_cpu_rd", cpu_readdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus_read(2'd1, r); chk("rst_ctrl", r, 32'd0);
    bus_read(2'd2, r); chk("rst_period", r, 32'd0);
    bus_read(2'd3, r); chk("rst_status", r, 32'd0);
    bus_read(2'd0, r); chk("pio_read_passthru", r, 32'h0000_1234);

    // Rotate, PERIOD=3, 15 writes spaced 5 cycles, back to 0x0001
    run_seq("rot", 0, 32'h0001, 3, 15);
    chk("rot_w1", qd(1), 32'h0002);
    chk("rot_w2", qd(2), 32'h0004);
    chk("rot_w14", qd(14), 32'h0001);

    // Bounce flips at bit 13
    run_seq("bnc", 1, 32'h1000, 0, 4);
    chk("bnc_w1", qd(1), 32'h2000);
    chk("bnc_w2", qd(2), 32'h1000);
    chk("bnc_w3", qd(3), 32'h0800);

    // Count wraps 3FFF -> 0
    run_seq("cnt", 2, 32'h3FFE, 2, 3);
    chk("cnt_w2", qd(2), 32'h0000);

    // Re-enable while enabled: mode changes to hold, seed ignored, no further writes
    bus_write(2'd2, 32'd4);
    q.delete();
    bus_write(2'd1, 32'h3FFE_0005);
    bus_write(2'd1, 32'h0055_0007);
    bus_read(2'd1, r);
    chk("ctrl_mode_only", r, 32'h3FFE_0007);
    idle(30);
    chk("hold_one_write", 32'(q.size()), 32'd1);
    chk("hold_value", qd(0), 32'h3FFE);
    bus_write(2'd1, 32'd0);

    // CPU PIO write collides with the engine ISSUE cycle
    bus_write(2'd2, 32'd3);
    q.delete();
    bus_write(2'd1, 32'h0005_0001);
    t0 = last_cyc;
    bus_write(2'd0, 32'h0000_0AAA);
    bus_read(2'd3, r);
    chk("defer_busy_pending", 32'(r[1:0]), 32'd3);
    wait_writes("defer", 3, 30);
    chk("defer_cpu_val", qd(0), 32'h0AAA);
    chk("defer_cpu_cyc", (q.size() > 0) ? 32'(q[0].cyc) : 32'hFFFF, 32'(t0 + 1));
    chk("defer_eng_val", qd(1), 32'h0005);
    chk("defer_eng_cyc", (q.size() > 1) ? 32'(q[1].cyc) : 32'hFFFF, 32'(t0 + 2));
    chk("defer_next_val", qd(2), 32'h000A);
    chk("defer_next_cyc", (q.size() > 2) ? 32'(q[2].cyc) : 32'hFFFF, 32'(t0 + 7));
    bus_write(2'd1, 32'd0);

    // Reset asserted while the engine is in ISSUE
    bus_write(2'd2, 32'd3);
    q.delete();
    bus_write(2'd1, 32'h0101_0001);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_issue_no_cs", 32'(pio_chipselect), 32'd0);
    @(posedge clk); #1;
    bus_read(2'd3, r);
    chk("rst_issue_status", r, 32'd0);
    reset_n = 1'b1;
    idle(30);
    chk("rst_issue_no_writes", 32'(q.size()), 32'd0);
    bus_read(2'd1, r);
    chk("rst_issue_ctrl", r, 32'd0);

    // Randomized runs
    for (int i = 0; i < 4; i++)
      run_seq($sformatf("rnd%0d", i), int'($urandom_range(0, 2)), int'($urandom_range(0, 16383)),
              int'($urandom_range(0, 6)), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pio_sequencer.md
Name: led_pio_sequencer

Overview:
Avalon-MM bridge and pattern engine in front of the 14-bit LED PIO slave port (s1). It arbitrates the single PIO port between the Nios CPU and an internal pattern engine, which autonomously writes rotate, bounce or count patterns at a programmable rate. CPU accesses to PIO data always take priority; the engine defers its write until the port is free.

Parameters:
LED_W, 14, width of the LED pattern and of the PIO data register
PERIOD_W, 24, width of the tick period register

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_address  in  2  word address: 0 = PIO data (pass-through), 1 = CTRL, 2 = PERIOD, 3 = STATUS
cpu_chipselect  in  1  CPU slave select
cpu_write_n  in  1  active-low CPU write strobe
cpu_writedata  in  32  CPU write data
cpu_readdata  out  32  CPU read data, combinational
pio_address  out  2  to PIO s1 address
pio_chipselect  out  1  to PIO s1 chipselect
pio_write_n  out  1  to PIO s1 write_n
pio_writedata  out  32  to PIO s1 writedata
pio_readdata  in  32  from PIO s1 readdata

Behaviour:
- Clock clk; reset reset_n, asynchronous, active-low. On reset: CTRL=0, PERIOD=0, pattern=0, dir=left, cnt=0, pending=0, state=IDLE.
- CTRL (addr 1, R/W): bit0 enable, bits[2:1] mode (0 rotate, 1 bounce, 2 count, 3 hold), bits[29:16] seed. PERIOD (addr 2, R/W): bits[23:0]. STATUS (addr 3, RO): bit0 busy (state != IDLE), bit1 pending, bits[29:16] current pattern. Reads of unused bits return 0.
- CPU port occupies the PIO when cpu_chipselect=1 and cpu_address=0. It is forwarded combinationally: pio_address=0, pio_chipselect=1, pio_write_n=cpu_write_n, pio_writedata=cpu_writedata, cpu_readdata=pio_readdata.
- Engine write, granted only when the CPU is not occupying the PIO: pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata={18'b0, pattern}.
- Idle PIO outputs: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0. cpu_readdata=0 when not reading.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: when a CTRL write sets enable 0->1, load pattern<=seed and dir<=left, then go to ISSUE on the next cycle.
  - ISSUE: raise pending. If granted this cycle, drive the write, clear pending, load cnt<=PERIOD, go to WAIT. If not granted, stay in ISSUE; the pattern is held.
  - WAIT: decrement cnt. At cnt==0 (tick): mode 3 reloads cnt and stays in WAIT with no write; other modes update pattern and go to ISSUE. One write occurs every PERIOD+2 cycles when uncontended. PERIOD=0 is legal.
- Pattern update rules:
  - rotate: {p[12:0], p[13]}
  - bounce: shift toward dir with zero fill; dir flips after the shift that sets bit 13 (now right) or bit 0 (now left). An all-zero pattern stays 0.
  - count: p+1 mod 2^14 (3FFF->0000).
- Latency: CTRL enable write at cycle N produces the engine PIO write at cycle N+1 if uncontended.
- A CTRL write with enable=1 while already enabled updates mode only; seed is ignored. A PERIOD write takes effect at the next cnt load.
- Clearing enable returns the FSM to IDLE the next cycle from any state, drops pending, and aborts the write; the PIO keeps its last value.
- A CPU PIO write and an engine ISSUE in the same cycle: the CPU write wins and the engine writes the following free cycle. The CPU value is therefore overwritten.

Optional Feature:
LED_SEQ_IRQ_EN: when defined, adds output irq (1 bit) and STATUS bit2 (wrap flag). The flag is set on count wrap 3FFF->0, on rotate when bit 13 rotates out as 1, and on each bounce direction flip. It is cleared by a CPU write to addr 3 with bit2=1; a set and a clear in the same cycle resolve to set. irq equals the flag, and the flag resets to 0. When undefined: no irq port and STATUS bit2 reads 0.

Test Plan:
- Reset, then read addr 1/2/3 -> all 0; pio_chipselect=0, pio_write_n=1.
- PERIOD=3, CTRL=enable|rotate|seed 0x0001 -> PIO writes 0x0001, 0x0002, 0x0004, ... spaced 5 cycles; after 14 ticks the pattern returns to 0x0001.
- Bounce with seed 0x1000, PERIOD=0 -> 0x1000, 0x2000, 0x1000, 0x0800 (direction flips at bit 13); IRQ build sets STATUS bit2 and irq.
- Count with seed 0x3FFE -> writes 0x3FFE, 0x3FFF, 0x0000; IRQ build sets the flag on the wrap, and writing 4 to addr 3 clears it.
- CPU writes 0x0AAA to addr 0 in the same cycle as an engine ISSUE -> PIO receives 0x0AAA, then the engine pattern the next cycle; STATUS bit1=1 during the deferral.
- Clear enable mid-WAIT, and separately assert reset_n=0 mid-ISSUE -> no further engine writes; busy=0 the next cycle (immediately on reset).
